// File: rtl/avalon_burst_splitter_pkg.sv
// Shared types and constants for the Avalon burst splitter: FSM state
// encoding, burstcount width and the per-beat byte stride helper.
package avalon_burst_splitter_pkg;

  localparam int BURSTCOUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR       = 2'd3
  } state_e;

  // Bytes covered by one beat; the address advances by this much per beat.
  function automatic int beat_bytes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/avalon_burst_splitter.sv
// Splits Avalon-MM bursts into single-beat accesses for a non-bursting bridge.
// Optional AVALON_BURST_SPLITTER_BYPASS_EN forwards single accesses without the latch cycle.
module avalon_burst_splitter
  import avalon_burst_splitter_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AW-1:0]           avs_address_i,
  input  logic [DW/8-1:0]         avs_byteenable_i,
  input  logic                    avs_read_i,
  input  logic                    avs_write_i,
  input  logic [DW-1:0]           avs_writedata_i,
  input  logic [BURSTCOUNT_W-1:0] avs_burstcount_i,
  output logic [DW-1:0]           avs_readdata_o,
  output logic                    avs_readdatavalid_o,
  output logic                    avs_waitrequest_o,
  output logic [AW-1:0]           avm_address_o,
  output logic [DW/8-1:0]         avm_byteenable_o,
  output logic                    avm_read_o,
  output logic                    avm_write_o,
  output logic [DW-1:0]           avm_writedata_o,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount_o,
  input  logic [DW-1:0]           avm_readdata_i,
  input  logic                    avm_readdatavalid_i,
  input  logic                    avm_waitrequest_i
);

`ifdef AVALON_BURST_SPLITTER_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  localparam logic [AW-1:0]           ADDR_STEP = AW'(beat_bytes(DW));
  localparam logic [BURSTCOUNT_W-1:0] ONE       = BURSTCOUNT_W'(1);

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [BURSTCOUNT_W-1:0] remaining_q, remaining_d;
  logic [DW/8-1:0]         be_q, be_d;

  logic [BURSTCOUNT_W-1:0] cmd_count;
  logic                    cmd_single;

  // A burstcount of zero is a one-beat access.
  assign cmd_count  = (avs_burstcount_i == '0) ? ONE : avs_burstcount_i;
  assign cmd_single = (avs_burstcount_i <= ONE);

  assign avs_readdata_o      = avm_readdata_i;
  assign avs_readdatavalid_o = avm_readdatavalid_i && (state_q == RD_WAIT) && !rst;
  assign avm_burstcount_o    = ONE;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d           = state_q;
    addr_d            = addr_q;
    remaining_d       = remaining_q;
    be_d              = be_q;
    avm_read_o        = 1'b0;
    avm_write_o       = 1'b0;
    avm_address_o     = addr_q;
    avm_byteenable_o  = be_q;
    avm_writedata_o   = avs_writedata_i;
    avs_waitrequest_o = 1'b1;

    case (state_q)
      IDLE: begin
        if (avs_read_i) begin
          if (BYPASS_EN && cmd_single) begin
            avm_read_o        = 1'b1;
            avm_address_o     = avs_address_i;
            avm_byteenable_o  = avs_byteenable_i;
            avs_waitrequest_o = avm_waitrequest_i;
            if (!avm_waitrequest_i) begin
              addr_d      = avs_address_i;
              be_d        = avs_byteenable_i;
              remaining_d = ONE;
              state_d     = RD_WAIT;
            end
          end else begin
            avs_waitrequest_o = 1'b0;
            addr_d            = avs_address_i;
            be_d              = avs_byteenable_i;
            remaining_d       = cmd_count;
            state_d           = RD_ISSUE;
          end
        end else if (avs_write_i) begin
          if (BYPASS_EN && cmd_single) begin
            avm_write_o       = 1'b1;
            avm_address_o     = avs_address_i;
            avm_byteenable_o  = avs_byteenable_i;
            avs_waitrequest_o = avm_waitrequest_i;
          end else begin
            // Beat 1 stays held upstream while the burst context is latched.
            addr_d      = avs_address_i;
            be_d        = avs_byteenable_i;
            remaining_d = cmd_count;
            state_d     = WR;
          end
        end
      end

      RD_ISSUE: begin
        avm_read_o = 1'b1;
        if (!avm_waitrequest_i) begin
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (avm_readdatavalid_i) begin
          addr_d      = addr_q + ADDR_STEP;
          remaining_d = remaining_q - ONE;
          state_d     = (remaining_q == ONE) ? IDLE : RD_ISSUE;
        end
      end

      WR: begin
        avm_write_o       = avs_write_i;
        avs_waitrequest_o = avm_waitrequest_i;
        if (avs_write_i && !avm_waitrequest_i) begin
          addr_d      = addr_q + ADDR_STEP;
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset must silence the bus immediately, not one edge later.
    if (rst) begin
      avm_read_o        = 1'b0;
      avm_write_o       = 1'b0;
      avs_waitrequest_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      be_q        <= be_d;
    end
  end

endmodule

// File: tb/tb_avalon_burst_splitter.sv
// Self-checking bench for avalon_burst_splitter: table of burst transactions
// against a bridge model, plus reset and latency sequences.
module tb_avalon_burst_splitter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] RD_KEY = 32'hC0DE_0000;

`ifdef AVALON_BURST_SPLITTER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   avs_address_i = '0;
  logic [DW/8-1:0] avs_byteenable_i = '0;
  logic            avs_read_i = 1'b0;
  logic            avs_write_i = 1'b0;
  logic [DW-1:0]   avs_writedata_i = '0;
  logic [7:0]      avs_burstcount_i = '0;
  logic [DW-1:0]   avs_readdata_o;
  logic            avs_readdatavalid_o;
  logic            avs_waitrequest_o;
  logic [AW-1:0]   avm_address_o;
  logic [DW/8-1:0] avm_byteenable_o;
  logic            avm_read_o;
  logic            avm_write_o;
  logic [DW-1:0]   avm_writedata_o;
  logic [7:0]      avm_burstcount_o;
  logic [DW-1:0]   avm_readdata_i = '0;
  logic            avm_readdatavalid_i = 1'b0;
  logic            avm_waitrequest_i = 1'b0;

  avalon_burst_splitter #(.DW(DW), .AW(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .avs_address_i       (avs_address_i),
    .avs_byteenable_i    (avs_byteenable_i),
    .avs_read_i          (avs_read_i),
    .avs_write_i         (avs_write_i),
    .avs_writedata_i     (avs_writedata_i),
    .avs_burstcount_i    (avs_burstcount_i),
    .avs_readdata_o      (avs_readdata_o),
    .avs_readdatavalid_o (avs_readdatavalid_o),
    .avs_waitrequest_o   (avs_waitrequest_o),
    .avm_address_o       (avm_address_o),
    .avm_byteenable_o    (avm_byteenable_o),
    .avm_read_o          (avm_read_o),
    .avm_write_o         (avm_write_o),
    .avm_writedata_o     (avm_writedata_o),
    .avm_burstcount_o    (avm_burstcount_o),
    .avm_readdata_i      (avm_readdata_i),
    .avm_readdatavalid_i (avm_readdatavalid_i),
    .avm_waitrequest_i   (avm_waitrequest_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Bridge configuration, written only by the stimulus process.
  int w_dflt = 0;
  int x_idx  = -1;
  int x_wait = 0;
  int rd_lat = 1;
  int clr_gen = 0;

  // Bridge state and logs, written only by the bridge process.
  int          seen_gen = 0;
  int          acc_n = 0;
  int          stall_left = 0;
  int          rd_left = 0;
  bit          busy = 1'b0;
  bit          rd_pend = 1'b0;
  bit          ovl = 1'b0;
  logic [31:0] rd_data = '0;
  logic [31:0] acc_addr[$];
  bit          acc_wr[$];
  logic [3:0]  acc_be[$];
  logic [31:0] acc_data[$];
  logic [31:0] rd_q[$];

  // Single-access bridge: optional waits per access, fixed read latency.
  always begin
    @(negedge clk);
    #1;
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      acc_addr.delete(); acc_wr.delete(); acc_be.delete(); acc_data.delete(); rd_q.delete();
      acc_n = 0; busy = 1'b0; rd_pend = 1'b0; ovl = 1'b0;
    end
    avm_readdatavalid_i = 1'b0;
    if (rd_pend) begin
      if (rd_left <= 1) begin
        avm_readdatavalid_i = 1'b1;
        avm_readdata_i      = rd_data;
        rd_pend             = 1'b0;
      end else begin
        rd_left--;
      end
    end
    if (avm_read_o && rd_pend) ovl = 1'b1;
    if ((avm_read_o || avm_write_o) && !rst) begin
      if (!busy) begin
        busy       = 1'b1;
        stall_left = (acc_n == x_idx) ? x_wait : w_dflt;
      end
      if (stall_left > 0) begin
        avm_waitrequest_i = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest_i = 1'b0;
        busy = 1'b0;
        acc_addr.push_back(avm_address_o);
        acc_wr.push_back(avm_write_o);
        acc_be.push_back(avm_byteenable_o);
        acc_data.push_back(avm_writedata_o);
        acc_n++;
        if (avm_read_o) begin
          rd_pend = 1'b1;
          rd_left = rd_lat;
          rd_data = avm_address_o ^ RD_KEY;
        end
      end
    end else begin
      avm_waitrequest_i = 1'b0;
      busy = 1'b0;
    end
    #1;
    if (avs_readdatavalid_o) rd_q.push_back(avs_readdata_o);
  end

  task automatic mst_read(input logic [31:0] addr, input logic [7:0] bc, input logic [3:0] be,
                          input bit both, input int beats, output int stalls, output bit wlow);
    bit done;
    int n;
    stalls = 0; wlow = 1'b0; done = 1'b0; n = 0;
    @(negedge clk);
    avs_address_i = addr; avs_burstcount_i = bc; avs_byteenable_i = be;
    avs_read_i = 1'b1; avs_write_i = both;
    while (!done && n < 100) begin
      #3;
      if (!avs_waitrequest_o) done = 1'b1;
      else begin stalls++; n++; @(negedge clk); end
    end
    if (!done) check("read accept timeout", 64'd0, 64'd1);
    @(negedge clk);
    avs_read_i = 1'b0; avs_write_i = 1'b0; avs_address_i = 32'hDEAD_BEEF;
    n = 0;
    while (rd_q.size() < beats && n < 200) begin
      #3;
      if (!avs_waitrequest_o) wlow = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic mst_write(input logic [31:0] addr, input logic [7:0] bc, input logic [3:0] be,
                           input logic [31:0] wbase, input bit gap,
                           output int stalls, output bit first);
    bit done;
    int n;
    int nb;
    stalls = 0; first = 1'b0;
    nb = (bc == 8'd0) ? 1 : int'(bc);
    @(negedge clk);
    avs_address_i = addr; avs_burstcount_i = bc; avs_byteenable_i = be;
    for (int i = 0; i < nb; i++) begin
      avs_write_i = 1'b1;
      avs_writedata_i = wbase + 32'(i);
      done = 1'b0; n = 0;
      while (!done && n < 100) begin
        #3;
        if (i == 0 && n == 0) first = avm_write_o;
        if (!avs_waitrequest_o) done = 1'b1;
        else begin stalls++; n++; @(negedge clk); end
      end
      if (!done) check("write accept timeout", 64'd0, 64'd1);
      @(negedge clk);
      // Burst context is only valid on beat 1; later values must be ignored.
      avs_address_i = 32'hDEAD_BEEF; avs_burstcount_i = 8'hFF;
      if (gap && i == 0) begin
        avs_write_i = 1'b0;
        avs_writedata_i = 32'hBAD0_BAD0;
        @(negedge clk);
      end
    end
    avs_write_i = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          is_wr;
    bit          both;
    logic [31:0] addr;
    logic [7:0]  bc;
    logic [3:0]  be;
    int          w_dflt;
    int          x_idx;
    int          x_wait;
    int          rd_lat;
    bit          gap;
    int          exp_beats;
    int          exp_stalls;
    bit          exp_first;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int          stalls;
    bit          first;
    bit          wlow;
    logic [31:0] wbase;
    logic [31:0] exp_a;
    wbase = 32'hA500_0000 + 32'(idx) * 32'h100;
    @(negedge clk);
    w_dflt = v.w_dflt; x_idx = v.x_idx; x_wait = v.x_wait; rd_lat = v.rd_lat;
    clr_gen++;
    stalls = 0; first = 1'b0; wlow = 1'b0;
    if (v.is_wr) mst_write(v.addr, v.bc, v.be, wbase, v.gap, stalls, first);
    else mst_read(v.addr, v.bc, v.be, v.both, v.exp_beats, stalls, wlow);
    repeat (4) @(negedge clk);
    check({v.name, " downstream beats"}, 64'(acc_n), 64'(v.exp_beats));
    for (int i = 0; i < v.exp_beats && i < acc_addr.size(); i++) begin
      exp_a = v.addr + 32'(4 * i);
      check($sformatf("%s addr[%0d]", v.name, i), 64'(acc_addr[i]), 64'(exp_a));
      check($sformatf("%s kind/be[%0d]", v.name, i), 64'({acc_wr[i], acc_be[i]}), 64'({v.is_wr, v.be}));
      if (v.is_wr)
        check($sformatf("%s wdata[%0d]", v.name, i), 64'(acc_data[i]), 64'(wbase + 32'(i)));
    end
    check({v.name, " upstream stalls"}, 64'(stalls), 64'(v.exp_stalls));
    if (v.is_wr) begin
      check({v.name, " first-cycle avm_write"}, 64'(first), 64'(v.exp_first));
    end else begin
      check({v.name, " returned beats"}, 64'(rd_q.size()), 64'(v.exp_beats));
      for (int i = 0; i < rd_q.size() && i < v.exp_beats; i++)
        check($sformatf("%s rdata[%0d]", v.name, i), 64'(rd_q[i]),
              64'((v.addr + 32'(4 * i)) ^ RD_KEY));
      check({v.name, " two reads outstanding"}, 64'(ovl), 64'd0);
      check({v.name, " waitrequest low before last valid"}, 64'(wlow), 64'd0);
    end
  endtask

  initial begin
    vec_t post;

    //           name               wr both addr          bc     be    wd xi  xw lat gap beats stalls     first
    vecs[0] = '{"rd4_0x100",       0, 0, 32'h0000_0100, 8'd4, 4'hF, 2, -1, 0, 1,  0,  4,   0,          0};
    vecs[1] = '{"rd0_0x40",        0, 0, 32'h0000_0040, 8'd0, 4'h3, 0, -1, 0, 2,  0,  1,   0,          0};
    vecs[2] = '{"rd1_0x80",        0, 0, 32'h0000_0080, 8'd1, 4'hF, 1, -1, 0, 1,  0,  1,   BYP ? 1 : 0, 0};
    vecs[3] = '{"rdwr_both_0x300", 0, 1, 32'h0000_0300, 8'd2, 4'hF, 0, -1, 0, 1,  0,  2,   0,          0};
    vecs[4] = '{"wr3_0x200",       1, 0, 32'h0000_0200, 8'd3, 4'hF, 0,  1, 3, 1,  0,  3,   4,          0};
    vecs[5] = '{"wr2_wrap",        1, 0, 32'hFFFF_FFFC, 8'd2, 4'hC, 0, -1, 0, 1,  1,  2,   1,          0};
    vecs[6] = '{"wr1_0x10",        1, 0, 32'h0000_0010, 8'd1, 4'hF, 0, -1, 0, 1,  0,  1,   BYP ? 0 : 1, BYP};

    // Reset state.
    repeat (3) @(negedge clk);
    #3;
    check("reset avs_waitrequest_o", 64'(avs_waitrequest_o), 64'd1);
    check("reset avm_read_o", 64'(avm_read_o), 64'd0);
    check("reset avm_write_o", 64'(avm_write_o), 64'd0);
    check("reset avs_readdatavalid_o", 64'(avs_readdatavalid_o), 64'd0);
    check("avm_burstcount_o", 64'(avm_burstcount_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

    // Reset while a 4-beat read sits in RD_WAIT; the late valid must be dropped.
    @(negedge clk);
    w_dflt = 0; x_idx = -1; x_wait = 0; rd_lat = 4;
    clr_gen++;
    @(negedge clk);
    avs_address_i = 32'h0000_0500; avs_burstcount_i = 8'd4; avs_byteenable_i = 4'hF;
    avs_read_i = 1'b1;
    #3;
    check("rst-mid: command accepted", 64'(avs_waitrequest_o), 64'd0);
    @(negedge clk);
    avs_read_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #3;
    check("rst-mid: avs_waitrequest_o", 64'(avs_waitrequest_o), 64'd1);
    check("rst-mid: avm_read_o", 64'(avm_read_o), 64'd0);
    check("rst-mid: avm_write_o", 64'(avm_write_o), 64'd0);
    check("rst-mid: avs_readdatavalid_o", 64'(avs_readdatavalid_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst-mid: late valid dropped", 64'(rd_q.size()), 64'd0);
    check("rst-mid: no beats after reset", 64'(acc_n), 64'd1);

    post = '{"rd2_after_rst", 0, 0, 32'h0000_0600, 8'd2, 4'hF, 0, -1, 0, 1, 0, 2, 0, 0};
    run_vec(post, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_burst_splitter.md
Name: avalon_burst_splitter

Overview:
- Sits directly upstream of the Avalon-to-Wishbone bridge.
- Accepts Avalon-MM burst commands (burstcount 1..255) from a bursting master, e.g. a DMA engine or cache refill.
- Issues them downstream as a sequence of single-beat Avalon accesses with incrementing address, because the bridge only supports single (CTI=111) Wishbone cycles.
- Holds at most one downstream read outstanding, matching the bridge's non-pipelined read path.

Parameters:
- DW, 32, data width in bits; must be a power of two and at least 8.
- AW, 32, byte address width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- avs_address_i  in  AW  burst start byte address.
- avs_byteenable_i  in  DW/8  byte enables, applied to every beat.
- avs_read_i  in  1  read command.
- avs_write_i  in  1  write beat valid.
- avs_writedata_i  in  DW  write data.
- avs_burstcount_i  in  8  beats in the burst; sampled on the first beat only.
- avs_readdata_o  out  DW  read data to the upstream master.
- avs_readdatavalid_o  out  1  read beat valid.
- avs_waitrequest_o  out  1  stall to the upstream master.
- avm_address_o  out  AW  single-beat address to the bridge.
- avm_byteenable_o  out  DW/8  byte enables to the bridge.
- avm_read_o  out  1  single read to the bridge.
- avm_write_o  out  1  single write to the bridge.
- avm_writedata_o  out  DW  write data to the bridge.
- avm_burstcount_o  out  8  constant 1.
- avm_readdata_i  in  DW  read data from the bridge.
- avm_readdatavalid_i  in  1  read data valid from the bridge.
- avm_waitrequest_i  in  1  stall from the bridge.

Behaviour:
- Reset: one clock, synchronous active-high. While rst is high: state=IDLE, avm_read_o=0, avm_write_o=0, avs_readdatavalid_o=0, avs_waitrequest_o=1.
- Registers: addr_q (AW bits), remaining_q (8 bits), be_q. addr_q increments by DW/8 per beat, wrapping modulo 2^AW. A burstcount of 0 is treated as 1.
- States: IDLE, RD_ISSUE, RD_WAIT, WR.
- IDLE, read command: avs_waitrequest_o=0, so the command is accepted in 1 cycle. Latch address, byteenable and count, then go to RD_ISSUE.
- IDLE, write command: avs_waitrequest_o=1, so beat 1 stays held by the master. Latch address, byteenable and count, then go to WR.
- IDLE, read and write asserted together: read wins.
- RD_ISSUE: avm_read_o=1, avm_address_o=addr_q. On !avm_waitrequest_i, go to RD_WAIT, with avm_read_o low in the next cycle. Read must drop after acceptance so the bridge does not restart a cycle.
- RD_WAIT: wait for avm_readdatavalid_i. On that beat, advance addr_q and decrement remaining_q. If remaining_q was 1, go to IDLE; otherwise go to RD_ISSUE.
- Read data path: avs_readdata_o=avm_readdata_i combinationally. avs_readdatavalid_o=avm_readdatavalid_i & (state==RD_WAIT). Stray or post-reset valids are dropped.
- Upstream stall in RD_ISSUE and RD_WAIT: avs_waitrequest_o=1.
- WR: pass-through of avs_write_i, writedata and be_q; address is addr_q; avs_waitrequest_o=avm_waitrequest_i.
- WR beat accept: a beat is accepted when avs_write_i & !avm_waitrequest_i. On accept, advance addr_q and decrement remaining_q. On the accept with remaining_q==1, go to IDLE.
- WR idle beats: if avs_write_i is low, no downstream write is issued and nothing advances.
- Latency: each read beat takes 1 cycle in RD_ISSUE, plus bridge latency, plus 1 cycle back to RD_ISSUE. The first write beat costs 1 extra cycle (the IDLE latch).
- Reset mid-burst: the burst is abandoned; no further beats are issued or returned.

Optional Feature:
- Macro: AVALON_BURST_SPLITTER_BYPASS_EN.
- With it defined, IDLE plus a command with burstcount<=1 is forwarded combinationally: avm_* = avs_* and avs_waitrequest_o=avm_waitrequest_i.
  - An accepted read goes to RD_WAIT with remaining_q=1.
  - An accepted write stays in IDLE.
  - The latch cycle is removed for single accesses.
- Without it, all commands take the registered path described above.

Decomposition:
- Package avalon_burst_splitter_pkg holds:
  - the state enum (IDLE, RD_ISSUE, RD_WAIT, WR, 2 bits);
  - the BEAT_BYTES = DW/8 function/constant;
  - the BURSTCOUNT_W = 8 constant.
- No sub-module: the counter and address incrementer are inline.

Test Plan:
- Read burst of 4 at 0x100, bridge acks after 2 cycles -> downstream reads at 0x100, 0x104, 0x108, 0x10C, never two outstanding; 4 readdatavalid beats returned in order; avs_waitrequest_o high until the last valid.
- Write burst of 3 at 0x200 with data A/B/C, downstream waitrequest held for 3 cycles on beat 2 -> writes A@0x200, B@0x204, C@0x208, each exactly once; upstream stalls mirror the downstream stalls.
- Burstcount 0 read at 0x40 -> exactly one read at 0x40, one valid returned, back to IDLE.
- Write burst of 2 at 0xFFFFFFFC -> beats at 0xFFFFFFFC and 0x00000000 (wrap).
- rst asserted in RD_WAIT of a 4-beat burst, followed by a late avm_readdatavalid_i -> avs_readdatavalid_o stays 0; outputs at reset values; a new read after reset completes normally.
- With BYPASS_EN, single write at 0x10 -> avm_write_o asserted in the same cycle as avs_write_i; with the macro undefined -> one cycle later.
